mem_bus_sequencer: RTL and testbench

- Parametrised successor of the top-level memory bus sequencer.
- Accepts one CPU bus transaction (byte, half or word, read or write) and serialises it into single-byte requests to NUM_SLAVES byte-wide submodules.
- Little-endian byte order; per-byte response timeout; error reporting for unmapped addresses, illegal sizes and timeouts.
- Sits between the CPU bus and the memory-mapped submodules (SDRAM controller, hex, GPIO, PS2, SD card, PLIC, RAMs).

---
 rtl/mem_bus_sequencer_if.sv | 40 ++++
 rtl/mem_bus_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_sequencer_if.sv
// CPU-side transaction bus plus byte-wide submodule bus for mem_bus_sequencer.
// slave modport: the sequencer. master modport: the CPU / memory-map side.
interface mem_bus_sequencer_if #(
    parameter int NUM_SLAVES = 13,
    parameter int ADDR_W     = 32,
    parameter int BUS_BYTES  = 4
);
    // CPU bus
    logic [8*BUS_BYTES-1:0]  i_bus_data;
    logic [ADDR_W-1:0]       i_bus_address;
    logic                    i_bus_DV;
    logic [2:0]              i_bhw;
    logic                    i_write_notread;
    logic [8*BUS_BYTES-1:0]  o_bus_data;
    logic                    o_bus_DV;
    logic                    o_bus_err;
    logic                    o_busy;
    // submodule bus
    logic [ADDR_W-1:0]       o_sub_address;
    logic [7:0]              o_sub_data;
    logic                    o_sub_write;
    logic [NUM_SLAVES-1:0]   o_sub_request;
    logic [NUM_SLAVES-1:0]   i_slave_sel;
    logic [8*NUM_SLAVES-1:0] i_sub_data;
    logic [NUM_SLAVES-1:0]   i_sub_receive;

    modport slave (
        input  i_bus_data, i_bus_address, i_bus_DV, i_bhw, i_write_notread,
        output o_bus_data, o_bus_DV, o_bus_err, o_busy,
        output o_sub_address, o_sub_data, o_sub_write, o_sub_request,
        input  i_slave_sel, i_sub_data, i_sub_receive
    );

    modport master (
        output i_bus_data, i_bus_address, i_bus_DV, i_bhw, i_write_notread,
        input  o_bus_data, o_bus_DV, o_bus_err, o_busy,
        input  o_sub_address, o_sub_data, o_sub_write, o_sub_request,
        output i_slave_sel, i_sub_data, i_sub_receive
    );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Serialises one CPU bus transaction (1/2/4/8 bytes) into little-endian
// single-byte requests to byte-wide submodules, with per-byte timeout and
// error reporting. Interface parameters must match the module parameters.
module mem_bus_sequencer #(
    parameter int NUM_SLAVES = 13,
    parameter int ADDR_W     = 32,
    parameter int BUS_BYTES  = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    mem_bus_sequencer_if.slave bus
);
    localparam int DW = 8 * BUS_BYTES;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      sub_data_q, sub_data_d;
    logic            write_q, write_d;
    logic [3:0]      nbytes_q, nbytes_d;
    logic [3:0]      k_q, k_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            sel_any;
    logic [IW-1:0]   sel_idx;
    logic            recv;
    logic [7:0]      rbyte;
    logic            size_ok;
    logic [3:0]      size_bytes;
    logic            last;
    logic [DW-1:0]   wshift;
    logic [TW-1:0]   tmo_inc;

    // Slave decode (lowest set bit wins), selected slave's strobe/data, size check
    always_comb begin
        sel_any = |bus.i_slave_sel;
        sel_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if (bus.i_slave_sel[i]) sel_idx = IW'(i);
        recv  = 1'b0;
        rbyte = 8'h00;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (idx_q == IW'(i)) begin
                recv  = bus.i_sub_receive[i];
                rbyte = bus.i_sub_data[8*i +: 8];
            end
        // 8 bytes cannot be encoded in three bits, so 3'b000 stands for 8 on wide buses
        size_bytes = (bus.i_bhw == 3'd0) ? 4'd8 : {1'b0, bus.i_bhw};
        size_ok    = (bus.i_bhw == 3'd1) || (bus.i_bhw == 3'd2) || (bus.i_bhw == 3'd4) ||
                     ((bus.i_bhw == 3'd0) && (BUS_BYTES == 8));
        last    = (4'(k_q + 4'd1) == nbytes_q);
        wshift  = wdata_q >> (8 * (int'(k_q) + 1));
        tmo_inc = tmo_q + 1'b1;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sub_data_d = sub_data_q;
        write_d    = write_q;
        nbytes_d   = nbytes_q;
        k_d        = k_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: if (bus.i_bus_DV) begin
                addr_d     = bus.i_bus_address;
                wdata_d    = bus.i_bus_data;
                sub_data_d = bus.i_bus_data[7:0];
                write_d    = bus.i_write_notread;
                nbytes_d   = size_bytes;
                k_d        = 4'd0;
                rdata_d    = '0;
                err_d      = !size_ok;
                state_d    = size_ok ? REQ : DONE;
            end
            REQ: if (!sel_any) begin
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = DONE;
            end else begin
                idx_d   = sel_idx;
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (recv) begin
                // receive beats a simultaneous timeout expiry
                if (!write_q)
                    for (int b = 0; b < BUS_BYTES; b++)
                        if (4'(b) == k_q) rdata_d[8*b +: 8] = rbyte;
                addr_d     = addr_q + 1'b1;
                k_d        = k_q + 4'd1;
                sub_data_d = wshift[7:0];
                state_d    = last ? DONE : REQ;
            end else begin
                tmo_d = tmo_inc;
                if (tmo_inc == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            sub_data_q <= '0;
            write_q    <= 1'b0;
            nbytes_q   <= '0;
            k_q        <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sub_data_q <= sub_data_d;
            write_q    <= write_d;
            nbytes_q   <= nbytes_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // One-cycle request to the decoded slave while in REQ
    always_comb begin
        bus.o_sub_request = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            bus.o_sub_request[i] = (state_q == REQ) && sel_any && (sel_idx == IW'(i));
    end

    assign bus.o_bus_DV      = (state_q == DONE);
    assign bus.o_bus_err     = (state_q == DONE) && err_q;
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_bus_data    = rdata_q;
    assign bus.o_sub_address = addr_q;
    assign bus.o_sub_data    = sub_data_q;
    assign bus.o_sub_write   = write_q;
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Self-checking bench for mem_bus_sequencer: directed scenarios plus randomized
// transactions against a byte-level memory/latency reference model.
module tb_mem_bus_sequencer;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int BB = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_sequencer_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .BUS_BYTES(BB)) bus ();
    mem_bus_sequencer #(.NUM_SLAVES(NS), .ADDR_W(AW), .BUS_BYTES(BB), .TIMEOUT(TO))
        dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        logic        wr;
        int          sl;
    } req_t;

    int checks = 0;
    int errors = 0;
    req_t log_q[$];
    logic [7:0] mem     [logic [31:0]];   // slave-side storage (responder only)
    logic [7:0] preset  [logic [31:0]];   // fixed contents written by tests
    logic [7:0] ref_mem [logic [31:0]];   // reference model storage
    int resp_delay = 1;
    bit sel_mode = 1'b0;
    logic [NS-1:0] sel_force = '0;
    logic [NS-1:0] extra_recv = '0;
    int dv_cnt = 0;

    function automatic logic [7:0] dflt(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic bit unmapped(logic [31:0] a);
        return a[15:12] == 4'hA;
    endfunction
    function automatic int slave_of(logic [31:0] a);
        return int'(a[13:12]);
    endfunction
    function automatic logic [7:0] init_byte(logic [31:0] a);
        return preset.exists(a) ? preset[a] : dflt(a);
    endfunction

    // External memory map
    logic [NS-1:0] one_hot_one = 1;
    assign bus.i_slave_sel = sel_mode ? sel_force :
                             (unmapped(bus.o_sub_address) ? '0 : (one_hot_one << slave_of(bus.o_sub_address)));

    // Slave responder: answers each request resp_delay cycles later (0 = never)
    bit   pend = 1'b0;
    int   pcnt = 0;
    req_t pr;
    initial begin
        bus.i_sub_receive = '0;
        bus.i_sub_data    = '0;
        forever begin
            @(negedge clk);
            bus.i_sub_receive = extra_recv;
            dv_cnt += int'(bus.o_bus_DV);
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    pend = 1'b0;
                    bus.i_sub_receive[pr.sl] = 1'b1;
                    if (pr.wr) mem[pr.addr] = pr.data;
                    else bus.i_sub_data[pr.sl*8 +: 8] = mem.exists(pr.addr) ? mem[pr.addr] : init_byte(pr.addr);
                end
            end
            if (|bus.o_sub_request) begin
                checks++;
                if ($countones(bus.o_sub_request) != 1) begin
                    errors++;
                    $display("FAIL req_onehot got=%b want one-hot", bus.o_sub_request);
                end
                for (int i = 0; i < NS; i++) if (bus.o_sub_request[i]) pr.sl = i;
                pr.addr = bus.o_sub_address;
                pr.data = bus.o_sub_data;
                pr.wr   = bus.o_sub_write;
                log_q.push_back(pr);
                if (resp_delay > 0) begin
                    pend = 1'b1;
                    pcnt = resp_delay;
                end
            end
        end
    end

    // Issue one transaction; lat = cycles from accept to o_bus_DV
    task automatic do_txn(input logic [31:0] a, input logic [2:0] bhw, input logic wr,
                          input logic [31:0] d, output int lat, output logic err, output logic [31:0] rd);
        @(negedge clk);
        bus.i_bus_address   = a;
        bus.i_bhw           = bhw;
        bus.i_write_notread = wr;
        bus.i_bus_data      = d;
        bus.i_bus_DV        = 1'b1;
        @(negedge clk);
        bus.i_bus_DV = 1'b0;
        lat = 1;
        while (!bus.o_bus_DV && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        err = bus.o_bus_err;
        rd  = bus.o_bus_data;
        checks++;
        if (!bus.o_bus_DV) begin
            errors++;
            $display("FAIL txn_done got=no o_bus_DV want=o_bus_DV within 400 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_bus_DV, bus.o_bus_err, bus.o_busy, bus.o_sub_write} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=0000", {bus.o_bus_DV, bus.o_bus_err, bus.o_busy, bus.o_sub_write});
        end
        checks++;
        if (bus.o_bus_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.o_bus_data); end
        checks++;
        if (bus.o_sub_address !== '0 || bus.o_sub_data !== '0) begin
            errors++; $display("FAIL reset_sub got=%h/%h want=0/0", bus.o_sub_address, bus.o_sub_data);
        end
        checks++;
        if (bus.o_sub_request !== '0) begin errors++; $display("FAIL reset_req got=%b want=0", bus.o_sub_request); end
        rst = 1'b0;
    endtask

    task automatic test_word_write();
        int lat; logic err; logic [31:0] rd;
        logic [31:0] w = 32'hDDCC_BBAA;
        int base = log_q.size();
        sel_mode = 1'b1; sel_force = 4'b0100; resp_delay = 1;
        do_txn(32'h1000, 3'd4, 1'b1, w, lat, err, rd);
        checks++; if (lat != 9) begin errors++; $display("FAIL ww_latency got=%0d want=9", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ww_err got=%b want=0", err); end
        @(negedge clk);
        checks++; if (bus.o_bus_DV !== 1'b0) begin errors++; $display("FAIL ww_dv_pulse got=%b want=0", bus.o_bus_DV); end
        checks++;
        if (log_q.size() - base != 4) begin errors++; $display("FAIL ww_nreq got=%0d want=4", log_q.size() - base); end
        else for (int k = 0; k < 4; k++) begin
            req_t r = log_q[base+k];
            checks++;
            if (r.addr !== 32'h1000 + k || r.data !== w[8*k +: 8] || r.wr !== 1'b1 || r.sl != 2) begin
                errors++;
                $display("FAIL ww_req%0d got=%h/%h/%b/%0d want=%h/%h/1/2", k, r.addr, r.data, r.wr, r.sl,
                         32'h1000 + k, w[8*k +: 8]);
            end
        end
    endtask

    task automatic test_half_read();
        int lat; logic err; logic [31:0] rd;
        sel_mode = 1'b1; sel_force = 4'b0001; resp_delay = 1;
        preset[32'h2002] = 8'h34; preset[32'h2003] = 8'h12;
        do_txn(32'h2002, 3'd2, 1'b0, 32'hFFFF_FFFF, lat, err, rd);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL hr_data got=%h want=00001234", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL hr_err got=%b want=0", err); end
        checks++; if (lat != 5) begin errors++; $display("FAIL hr_latency got=%0d want=5", lat); end
    endtask

    task automatic test_timeout();
        int lat; logic err; logic [31:0] rd; int dv0;
        int base = log_q.size();
        sel_mode = 1'b1; sel_force = 4'b0001; resp_delay = 0;
        do_txn(32'h2000, 3'd4, 1'b0, 32'h0, lat, err, rd);
        checks++; if (lat != TO + 2) begin errors++; $display("FAIL to_latency got=%0d want=%0d", lat, TO + 2); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got=%b want=1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL to_data got=%h want=0", rd); end
        checks++; if (log_q.size() - base != 1) begin errors++; $display("FAIL to_nreq got=%0d want=1", log_q.size() - base); end
        @(negedge clk);
        dv0 = dv_cnt;
        extra_recv = 4'b0001;
        @(negedge clk);
        extra_recv = '0;
        repeat (4) @(negedge clk);
        checks++; if (dv_cnt != dv0) begin errors++; $display("FAIL to_late_recv got=%0d dv want=0", dv_cnt - dv0); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL to_late_busy got=%b want=0", bus.o_busy); end
        resp_delay = 1;
    endtask

    task automatic test_unmapped();
        int lat; logic err; logic [31:0] rd;
        int base = log_q.size();
        sel_mode = 1'b1; sel_force = '0; resp_delay = 1;
        do_txn(32'h7000, 3'd1, 1'b1, 32'h55, lat, err, rd);
        checks++; if (lat != 2 || err !== 1'b1) begin errors++; $display("FAIL unmapped got=lat%0d/err%b want=lat2/err1", lat, err); end
        sel_force = 4'b0010;
        do_txn(32'h7000, 3'd3, 1'b1, 32'h55, lat, err, rd);
        checks++; if (lat != 1 || err !== 1'b1) begin errors++; $display("FAIL illegal_size got=lat%0d/err%b want=lat1/err1", lat, err); end
        checks++; if (log_q.size() != base) begin errors++; $display("FAIL err_noreq got=%0d want=0", log_q.size() - base); end
    endtask

    task automatic test_busy();
        int lat; logic err; logic [31:0] rd; int dv0;
        logic [31:0] exp;
        int base = log_q.size();
        sel_mode = 1'b1; sel_force = 4'b0010; resp_delay = 3;
        for (int k = 0; k < 4; k++) exp[8*k +: 8] = init_byte(32'h3000 + k);
        dv0 = dv_cnt;
        fork
            do_txn(32'h3000, 3'd4, 1'b0, 32'h0, lat, err, rd);
            begin
                repeat (3) @(negedge clk);
                checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL busy_high got=%b want=1", bus.o_busy); end
                bus.i_bus_address = 32'h5000; bus.i_bhw = 3'd1; bus.i_bus_DV = 1'b1;
                extra_recv = 4'b0100;
                @(negedge clk);
                bus.i_bus_DV = 1'b0; extra_recv = '0;
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (lat != 17) begin errors++; $display("FAIL busy_latency got=%0d want=17", lat); end
        checks++; if (rd !== exp || err !== 1'b0) begin errors++; $display("FAIL busy_data got=%h/%b want=%h/0", rd, err, exp); end
        checks++; if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL busy_one_dv got=%0d want=1", dv_cnt - dv0); end
        checks++; if (log_q.size() - base != 4) begin errors++; $display("FAIL busy_nreq got=%0d want=4", log_q.size() - base); end
        resp_delay = 1;
    endtask

    task automatic test_reset_mid();
        int lat; logic err; logic [31:0] rd; int dv0; int n;
        sel_mode = 1'b1; sel_force = 4'b1000; resp_delay = 1;
        dv0 = dv_cnt;
        @(negedge clk);
        bus.i_bus_address = 32'h4000; bus.i_bhw = 3'd4; bus.i_write_notread = 1'b0; bus.i_bus_DV = 1'b1;
        @(negedge clk);
        bus.i_bus_DV = 1'b0;
        n = 0;
        while (bus.o_sub_address !== 32'h4001 && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL rm_byte1 got=addr %h want=00004001", bus.o_sub_address); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.o_bus_DV, bus.o_bus_err, bus.o_busy, bus.o_sub_write, bus.o_sub_request, bus.o_bus_data,
             bus.o_sub_address, bus.o_sub_data} !== '0) begin
            errors++; $display("FAIL rm_outputs got=busy%b addr%h data%h want=all 0", bus.o_busy, bus.o_sub_address, bus.o_bus_data);
        end
        repeat (5) @(negedge clk);
        checks++; if (dv_cnt != dv0) begin errors++; $display("FAIL rm_no_dv got=%0d want=0", dv_cnt - dv0); end
        do_txn(32'h4000, 3'd1, 1'b0, 32'h0, lat, err, rd);
        checks++;
        if (lat != 3 || err !== 1'b0 || rd !== {24'h0, init_byte(32'h4000)}) begin
            errors++; $display("FAIL rm_after got=lat%0d/err%b/%h want=lat3/err0/%h", lat, err, rd, {24'h0, init_byte(32'h4000)});
        end
    endtask

    task automatic test_random();
        logic [2:0] sizes [9] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd2, 3'd1, 3'd3, 3'd0, 3'd5};
        sel_mode = 1'b0;
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a, d, rd, exp_rd; logic [2:0] bhw; logic wr, err, exp_err;
            int lat, exp_lat, dly, n, base;
            req_t exp_q[$];
            case ($urandom_range(0, 3))
                0: a = {16'h0, 16'($urandom)};
                1: a = 32'hFFFF_FFFC + $urandom_range(0, 3);
                2: a = 32'h0000_9FFD + $urandom_range(0, 2);
                default: a = $urandom;
            endcase
            bhw = sizes[$urandom_range(0, 8)];
            wr  = 1'($urandom);
            d   = $urandom;
            dly = $urandom_range(1, 3);
            resp_delay = dly;
            // Reference model: byte-serial walk of the transaction
            exp_rd = '0; exp_err = 1'b0;
            if (!(bhw == 3'd1 || bhw == 3'd2 || bhw == 3'd4)) begin
                exp_err = 1'b1; exp_lat = 1;
            end else begin
                n = int'(bhw);
                exp_lat = 1 + n * (dly + 1);
                for (int k = 0; k < n; k++) begin
                    logic [31:0] ba = a + k;
                    req_t r;
                    if (unmapped(ba)) begin
                        exp_err = 1'b1; exp_lat = 2 + k * (dly + 1);
                        break;
                    end
                    r.addr = ba; r.data = d[8*k +: 8]; r.wr = wr; r.sl = slave_of(ba);
                    exp_q.push_back(r);
                    if (wr) ref_mem[ba] = d[8*k +: 8];
                    else exp_rd[8*k +: 8] = ref_mem.exists(ba) ? ref_mem[ba] : init_byte(ba);
                end
                if (exp_err) exp_rd = '0;
            end
            base = log_q.size();
            do_txn(a, bhw, wr, d, lat, err, rd);
            checks++;
            if (lat != exp_lat || err !== exp_err || rd !== exp_rd) begin
                errors++;
                $display("FAIL rnd%0d a=%h bhw=%0d wr=%b got=lat%0d/err%b/%h want=lat%0d/err%b/%h",
                         it, a, bhw, wr, lat, err, rd, exp_lat, exp_err, exp_rd);
            end
            checks++;
            if (log_q.size() - base != exp_q.size()) begin
                errors++; $display("FAIL rnd%0d_nreq got=%0d want=%0d", it, log_q.size() - base, exp_q.size());
            end else foreach (exp_q[k]) begin
                req_t g = log_q[base+k];
                checks++;
                if (g.addr !== exp_q[k].addr || g.wr !== exp_q[k].wr || g.sl != exp_q[k].sl ||
                    (exp_q[k].wr && g.data !== exp_q[k].data)) begin
                    errors++;
                    $display("FAIL rnd%0d_req%0d got=%h/%h/%b/%0d want=%h/%h/%b/%0d", it, k, g.addr, g.data, g.wr, g.sl,
                             exp_q[k].addr, exp_q[k].data, exp_q[k].wr, exp_q[k].sl);
                end
            end
        end
        resp_delay = 1;
    endtask

    initial begin
        bus.i_bus_data = '0; bus.i_bus_address = '0; bus.i_bus_DV = 1'b0;
        bus.i_bhw = 3'd0; bus.i_write_notread = 1'b0;
        test_reset();
        test_word_write();
        test_half_read();
        test_timeout();
        test_unmapped();
        test_busy();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
